// File: rtl/out_display.sv
// Three-digit decimal display driver: latches an 8-bit value, converts it to BCD with a
// sequential double-dabble engine and scans it onto a multiplexed 7-segment display.
module out_display #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter bit          LZB      = 1'b1
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [7:0]  data_in,
   input  logic        load,
   output logic        busy,
   output logic [11:0] bcd,
   output logic [2:0]  an,
   output logic [6:0]  seg
);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t      state_q, state_d;
   logic [19:0] sh_q, sh_d;
   logic [2:0]  iter_q, iter_d;
   logic [7:0]  pend_q, pend_d;
   logic        pend_v_q, pend_v_d;
   logic [11:0] bcd_q, bcd_d;
   logic [15:0] presc_q, presc_d;
   logic [1:0]  idx_q, idx_d;
   logic [2:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic [3:0]  nib;
   logic        blank;

   // One double-dabble iteration: adjust each BCD nibble >= 5 by +3, then shift left.
   function automatic logic [19:0] dd_step(input logic [19:0] s);
      logic [19:0] t;
      t = s;
      for (int k = 0; k < 3; k++) begin
         if (t[8+4*k +: 4] >= 4'd5) t[8+4*k +: 4] = t[8+4*k +: 4] + 4'd3;
      end
      return {t[18:0], 1'b0};
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 7'h40;
         4'd1:    glyph = 7'h79;
         4'd2:    glyph = 7'h24;
         4'd3:    glyph = 7'h30;
         4'd4:    glyph = 7'h19;
         4'd5:    glyph = 7'h12;
         4'd6:    glyph = 7'h02;
         4'd7:    glyph = 7'h78;
         4'd8:    glyph = 7'h00;
         4'd9:    glyph = 7'h10;
         default: glyph = 7'h7F;
      endcase
   endfunction

   // Conversion FSM; a load arriving on the DONE edge outranks an older pending value.
   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      iter_d   = iter_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      bcd_d    = bcd_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               sh_d    = {12'd0, data_in};
               iter_d  = 3'd0;
               state_d = CONV;
            end
         end
         CONV: begin
            sh_d   = dd_step(sh_q);
            iter_d = iter_q + 3'd1;
            if (iter_q == 3'd7) state_d = DONE;
            if (load) begin
               pend_d   = data_in;
               pend_v_d = 1'b1;
            end
         end
         DONE: begin
            bcd_d    = sh_q[19:8];
            pend_v_d = 1'b0;
            iter_d   = 3'd0;
            if (load) begin
               sh_d    = {12'd0, data_in};
               state_d = CONV;
            end else if (pend_v_q) begin
               sh_d    = {12'd0, pend_q};
               state_d = CONV;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Scan runs freely; an/seg are computed from next-state values so they change on the
   // same edge as the digit index or the displayed value.
   always_comb begin
      presc_d = presc_q + 16'd1;
      idx_d   = idx_q;
      if (presc_q == 16'(SCAN_DIV - 1)) begin
         presc_d = 16'd0;
         idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end
      nib   = bcd_d[3:0];
      blank = 1'b0;
      an_d  = 3'b110;
      case (idx_d)
         2'd1: begin
            an_d  = 3'b101;
            nib   = bcd_d[7:4];
            blank = LZB && (bcd_d[11:8] == 4'd0) && (bcd_d[7:4] == 4'd0);
         end
         2'd2: begin
            an_d  = 3'b011;
            nib   = bcd_d[11:8];
            blank = LZB && (bcd_d[11:8] == 4'd0);
         end
         default: ;
      endcase
      seg_d = blank ? 7'h7F : glyph(nib);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= IDLE;
         sh_q     <= 20'd0;
         iter_q   <= 3'd0;
         pend_q   <= 8'd0;
         pend_v_q <= 1'b0;
         bcd_q    <= 12'h000;
         presc_q  <= 16'd0;
         idx_q    <= 2'd0;
         an_q     <= 3'b110;
         seg_q    <= 7'h40;
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         iter_q   <= iter_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         bcd_q    <= bcd_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign bcd  = bcd_q;
   assign an   = an_q;
   assign seg  = seg_q;

endmodule

// File: tb/tb_out_display.sv
// Bench for out_display: two instances (blanking on/off) with a short scan divider,
// a BCD scoreboard fed at load time and drained whenever the displayed value changes.
module tb_out_display;

   logic        clk;
   logic        clr;
   logic [7:0]  data_in;
   logic        load;
   logic        busy1, busy0;
   logic [11:0] bcd1, bcd0;
   logic [2:0]  an1, an0;
   logic [6:0]  seg1, seg0;

   logic [11:0] exp_q[$];
   logic [11:0] prev_bcd;
   int          n_checks;
   int          n_pass;

   out_display #(.SCAN_DIV(4), .LZB(1'b1)) dut1 (
      .clk(clk), .clr(clr), .data_in(data_in), .load(load),
      .busy(busy1), .bcd(bcd1), .an(an1), .seg(seg1)
   );

   out_display #(.SCAN_DIV(4), .LZB(1'b0)) dut0 (
      .clk(clk), .clr(clr), .data_in(data_in), .load(load),
      .busy(busy0), .bcd(bcd0), .an(an0), .seg(seg0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [11:0] to_bcd(input logic [7:0] v);
      int x;
      x = v;
      return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
   endfunction

   function automatic logic [2:0] an_model(input int k);
      case ((k / 4) % 3)
         0:       return 3'b110;
         1:       return 3'b101;
         default: return 3'b011;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] v, input bit replace);
      if (replace && exp_q.size() > 0) void'(exp_q.pop_back());
      exp_q.push_back(to_bcd(v));
      data_in = v;
      load    = 1'b1;
      tick();
      load    = 1'b0;
   endtask

   // Watch for every displayed-value change and compare against the oldest expectation.
   initial begin
      prev_bcd = 12'h000;
      forever begin
         @(negedge clk);
         if (clr) prev_bcd = bcd1;
         else if (bcd1 !== prev_bcd) begin
            if (exp_q.size() == 0) check("sb_unexpected", bcd1, prev_bcd);
            else check("sb_bcd", bcd1, exp_q.pop_front());
            prev_bcd = bcd1;
         end
      end
   end

   task automatic check_scan(input logic [6:0] e0, e1, e2, input logic [6:0] f0, f1, f2);
      logic [2:0] seen;
      seen = 3'b000;
      for (int i = 0; i < 12; i++) begin
         tick();
         case (an1)
            3'b110: if (!seen[0]) begin check("seg_ones", seg1, e0); check("seg0_ones", seg0, f0); seen[0] = 1'b1; end
            3'b101: if (!seen[1]) begin check("seg_tens", seg1, e1); check("seg0_tens", seg0, f1); seen[1] = 1'b1; end
            3'b011: if (!seen[2]) begin check("seg_hund", seg1, e2); check("seg0_hund", seg0, f2); seen[2] = 1'b1; end
            default: check("an_onehot", an1, 3'b110);
         endcase
      end
      check("scan_cover", seen, 3'b111);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      clr      = 1'b1;
      load     = 1'b0;
      data_in  = 8'h00;
      #2;
      check("rst_busy", busy1, 1'b0);
      check("rst_bcd", bcd1, 12'h000);
      check("rst_an", an1, 3'b110);
      check("rst_seg", seg1, 7'h40);
      check("rst_seg_lzb0", seg0, 7'h40);
      tick();
      clr = 1'b0;
      tick();

      // Full-scale conversion and its latency.
      drive(8'hFF, 1'b0);
      check("ff_busy_n", busy1, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("ff_busy", busy1, 1'b1);
         check("ff_hold", bcd1, 12'h000);
      end
      tick();
      check("ff_bcd", bcd1, 12'h255);
      check("ff_idle", busy1, 1'b0);
      check_scan(7'h12, 7'h12, 7'h24, 7'h12, 7'h12, 7'h24);

      // Leading-zero blanking versus plain zeros.
      drive(8'h07, 1'b0);
      for (int i = 1; i <= 9; i++) tick();
      check("b7_bcd", bcd1, 12'h007);
      check("b7_bcd_lzb0", bcd0, 12'h007);
      check_scan(7'h78, 7'h7F, 7'h7F, 7'h78, 7'h40, 7'h40);

      // Overrun: 200 is overwritten by 34 while still pending.
      drive(8'd12, 1'b0);
      tick(); tick();
      check("ov_busy3", busy1, 1'b1);
      drive(8'd200, 1'b0);
      tick();
      drive(8'd34, 1'b1);
      for (int k = 6; k <= 18; k++) begin
         tick();
         if (k < 18) check("ov_busy", busy1, 1'b1);
         if (k == 9) check("ov_bcd12", bcd1, 12'h012);
      end
      check("ov_bcd34", bcd1, 12'h034);
      check("ov_idle", busy1, 1'b0);

      // Abort mid-conversion; the scan restarts from index 0.
      drive(8'h80, 1'b0);
      tick(); tick();
      clr = 1'b1;
      exp_q.delete();
      #1;
      check("ab_busy", busy1, 1'b0);
      check("ab_bcd", bcd1, 12'h000);
      check("ab_an", an1, 3'b110);
      check("ab_seg", seg1, 7'h40);
      tick();
      clr = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         check("ab_stay_bcd", bcd1, 12'h000);
         check("ab_stay_busy", busy1, 1'b0);
         check("ab_scan_an", an1, an_model(k));
      end

      // Load on the first edge after clr releases; scan must not notice it.
      clr = 1'b1;
      #1;
      clr = 1'b0;
      drive(8'd99, 1'b0);
      check("rl_busy", busy1, 1'b1);
      check("rl_an", an1, an_model(1));
      for (int k = 2; k <= 14; k++) begin
         tick();
         check("rl_scan_an", an1, an_model(k));
         if (k < 10) check("rl_busy_k", busy1, 1'b1);
         if (k == 10) begin
            check("rl_bcd", bcd1, 12'h099);
            check("rl_idle", busy1, 1'b0);
         end
      end

      tick();
      check("sb_drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
